conv3x3_filter_top: RTL and testbench

//  Streaming 3x3 image filter for 8-bit greyscale frames, IMG_WIDTH pixels per line.

---
 rtl/conv3x3_pkg.sv | 16 +
 rtl/conv3x3_line_buffer.sv | 22 ++
 rtl/conv3x3_filter_top.sv | 101 ++++++++++
 tb/tb_conv3x3_filter_top.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_pkg.sv
// conv3x3_pkg: shared defaults, kernel coefficients, read FSM states and clamp for the 3x3 filter (KERNEL_BLUR_EN selects Gaussian blur)
package conv3x3_pkg;
  localparam int IMG_WIDTH_DEF = 512;
  localparam int DATA_W_DEF = 8;
`ifdef KERNEL_BLUR_EN
  localparam int SUM_W = 13;
  localparam int KERNEL [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
`else
  localparam int SUM_W = 12;
  localparam int KERNEL [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
`endif
  typedef enum logic {IDLE, RD_LINE} rd_state_t;
  function automatic logic [7:0] clamp(input logic signed [SUM_W-1:0] s);
    return s[SUM_W-1] ? 8'd0 : (|s[SUM_W-2:8]) ? 8'd255 : s[7:0];
  endfunction
endpackage

// File: rtl/conv3x3_line_buffer.sv
// line_buffer: one image line; write port clk/we/waddr/wdata, combinational taps at col-1/col/col+1 (zero outside the line)
module line_buffer import conv3x3_pkg::*; #(
  parameter int W = IMG_WIDTH_DEF,
  parameter int DW = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(W)-1:0]       waddr,
  input  logic [DW-1:0]              wdata,
  input  logic [$clog2(W)-1:0]       col,
  output logic [2:0][DW-1:0]         taps
);
  localparam int AW = $clog2(W);
  logic [DW-1:0] mem [W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_comb begin
    taps[0] = col == '0 ? '0 : mem[col - 1'b1];
    taps[1] = mem[col];
    taps[2] = col == AW'(W - 1) ? '0 : mem[col + 1'b1];
  end
endmodule

// File: rtl/conv3x3_filter_top.sv
// conv3x3_filter_top: streaming 3x3 filter over four round-robin line buffers (sharpen; Gaussian blur when KERNEL_BLUR_EN)
// Ports: axis_clk clock, axis_resetn sync active-high reset, i_datavalid/idata/s_axis_ready pixel input,
// o_datavalid/odata/m_axis_ready pixel output, intr one-cycle pulse per freed line buffer.
module conv3x3_filter_top import conv3x3_pkg::*; #(
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              axis_clk,
  input  logic              axis_resetn,
  input  logic              i_datavalid,
  input  logic [DATA_W-1:0] idata,
  output logic              s_axis_ready,
  output logic              o_datavalid,
  output logic [DATA_W-1:0] odata,
  input  logic              m_axis_ready,
  output logic              intr
);
  localparam int AW = $clog2(IMG_WIDTH);
  localparam int FW = $clog2(4 * IMG_WIDTH + 1);
  logic [AW-1:0] wcol, rcol;
  logic [1:0] wbuf, rbuf;
  logic [FW-1:0] fill;
  rd_state_t state, state_nx;
  logic accept, stall, rd_go, last, s1_v, s2_v;
  logic [3:0][2:0][DATA_W-1:0] taps;
  logic [8:0][DATA_W-1:0] win, s1_win;
  logic signed [SUM_W-1:0] s2_sum;
  int mac;
  assign s_axis_ready = fill < FW'(4 * IMG_WIDTH);
  assign accept = i_datavalid & s_axis_ready;
  assign stall = o_datavalid & ~m_axis_ready;
  assign rd_go = state == RD_LINE & ~stall;
  assign last = rd_go & rcol == AW'(IMG_WIDTH - 1);
  for (genvar g = 0; g < 4; g++) begin : g_lb
    line_buffer #(.W(IMG_WIDTH), .DW(DATA_W)) u_lb (
      .clk(axis_clk),
      .we(accept && wbuf == 2'(g)),
      .waddr(wcol),
      .wdata(idata),
      .col(rcol),
      .taps(taps[g])
    );
  end
  always_comb begin
    win = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r*3+c] = taps[2'(rbuf + 2'(r))][c];
  end
  always_comb begin
    mac = 0;
    for (int i = 0; i < 9; i++)
      mac += int'(s1_win[i]) * KERNEL[i];
  end
  always_comb begin
    state_nx = state;
    if (!stall)
      state_nx = state == IDLE ? (fill >= FW'(3 * IMG_WIDTH) ? RD_LINE : IDLE) : (last ? IDLE : RD_LINE);
  end
  always_ff @(posedge axis_clk) begin
    if (axis_resetn) begin
      state <= IDLE;
      wcol <= '0;
      wbuf <= '0;
      rcol <= '0;
      rbuf <= '0;
      fill <= '0;
      intr <= 1'b0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_win <= '0;
      s2_sum <= '0;
      o_datavalid <= 1'b0;
      odata <= '0;
    end else begin
      state <= state_nx;
      intr <= last;
      fill <= fill + FW'(accept) - (last ? FW'(IMG_WIDTH) : FW'(0));
      if (accept) begin
        wcol <= wcol == AW'(IMG_WIDTH - 1) ? '0 : wcol + 1'b1;
        if (wcol == AW'(IMG_WIDTH - 1)) wbuf <= wbuf + 1'b1;
      end
      if (rd_go) begin
        rcol <= last ? '0 : rcol + 1'b1;
        if (last) rbuf <= rbuf + 1'b1;
      end
      if (!stall) begin
        s1_v <= rd_go;
        s1_win <= win;
        s2_v <= s1_v;
        s2_sum <= SUM_W'(mac);
        o_datavalid <= s2_v;
`ifdef KERNEL_BLUR_EN
        odata <= DATA_W'(s2_sum >>> 4);
`else
        odata <= DATA_W'(clamp(s2_sum));
`endif
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_filter_top.sv
// tb_conv3x3_filter_top: randomized self-checking bench for conv3x3_filter_top against an arithmetic 3x3 reference
module tb_conv3x3_filter_top;
  localparam int W = 16;
  localparam int ML = W + 2;
`ifdef KERNEL_BLUR_EN
  localparam int KERN [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  localparam int EDGE = 75;
  localparam int PK_C = 63;
  localparam int PK_S = 31;
`else
  localparam int KERN [3][3] = '{'{0, -1, 0}, '{-1, 5, -1}, '{0, -1, 0}};
  localparam int EDGE = 200;
  localparam int PK_C = 255;
  localparam int PK_S = 0;
`endif
  logic clk = 0, rst = 1, i_datavalid = 0, m_axis_ready = 1;
  logic [7:0] idata = 0;
  logic s_axis_ready, o_datavalid, intr;
  logic [7:0] odata;
  int img [ML][W];
  int exp_q[$];
  int got[$];
  int n_vec = 0, n_err = 0, n_intr = 0, rdy_mode = 1;
  conv3x3_filter_top #(.IMG_WIDTH(W), .DATA_W(8)) dut (
    .axis_clk(clk),
    .axis_resetn(rst),
    .i_datavalid(i_datavalid),
    .idata(idata),
    .s_axis_ready(s_axis_ready),
    .o_datavalid(o_datavalid),
    .odata(odata),
    .m_axis_ready(m_axis_ready),
    .intr(intr)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string tag, input int got_v, input int exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got_v, exp_v);
    end
  endtask
  function automatic int ref_pix(input int k, input int c);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int d = -1; d <= 1; d++)
        if (c + d >= 0 && c + d < W) s += KERN[r][d+1] * img[k+r][c+d];
`ifdef KERNEL_BLUR_EN
    return s / 16;
`else
    return s < 0 ? 0 : (s > 255 ? 255 : s);
`endif
  endfunction
  task automatic fill_img(input int n, input int mode);
    for (int l = 0; l < ML; l++)
      for (int c = 0; c < W; c++)
        img[l][c] = l >= n ? 0 : mode == 0 ? 100 : mode == 1 ? 0 : (mode == 3 && l >= n - 2) ? 0 : int'($urandom_range(255));
    if (mode == 1) img[1][10] = 255;
  endtask
  task automatic build_exp(input int k0, input int k1);
    for (int k = k0; k < k1; k++)
      for (int c = 0; c < W; c++) exp_q.push_back(ref_pix(k, c));
  endtask
  task automatic push(input int first, input int n, input int gap_pct);
    int idx = first;
    int t = 0;
    while (idx < first + n && t < 20000) begin
      @(negedge clk);
      i_datavalid = $urandom_range(99) >= gap_pct;
      idata = 8'(img[idx/W][idx%W]);
      #2;
      if (i_datavalid && s_axis_ready) idx++;
      t++;
    end
    @(negedge clk) i_datavalid = 0;
    chk("push_done", idx, first + n);
  endtask
  task automatic wait_got(input int n);
    int t = 0;
    while (got.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
  endtask
  task automatic wait_out(input int n, input int rows);
    wait_got(n);
    repeat (10) @(negedge clk);
    chk("out_count", got.size(), n);
    chk("exp_left", exp_q.size(), 0);
    chk("intr_count", n_intr, rows);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    i_datavalid = 0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    got.delete();
    n_intr = 0;
    rst = 0;
  endtask
  initial forever begin
    @(negedge clk);
    m_axis_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(3) != 0);
  end
  initial begin
    bit prev_stall = 0;
    int prev_data = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_valid", o_datavalid, 1);
        chk("hold_data", odata, prev_data);
      end
      prev_stall = o_datavalid && !m_axis_ready;
      prev_data = odata;
      if (intr) n_intr++;
      if (o_datavalid && m_axis_ready) begin
        got.push_back(odata);
        if (exp_q.size() == 0) chk("extra_out", 1, 0);
        else chk("pixel", odata, exp_q.pop_front());
      end
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_valid", o_datavalid, 0);
    chk("rst_data", odata, 0);
    chk("rst_intr", intr, 0);
    chk("rst_ready", s_axis_ready, 1);
    do_reset();
    fill_img(4, 0);
    build_exp(0, 1);
    push(0, 3 * W, 0);
    wait_out(W, 1);
    chk("uni_col0", got[0], EDGE);
    chk("uni_mid", got[W/2], 100);
    chk("uni_last", got[W-1], EDGE);
    build_exp(1, 2);
    push(3 * W, W, 0);
    wait_out(2 * W, 2);
    do_reset();
    fill_img(3, 1);
    build_exp(0, 1);
    push(0, 3 * W, 30);
    wait_out(W, 1);
    chk("peak_c10", got[10], PK_C);
    chk("peak_c9", got[9], PK_S);
    chk("peak_c11", got[11], PK_S);
    do_reset();
    fill_img(4, 2);
    build_exp(0, 2);
    push(0, 3 * W, 0);
    wait_got(5);
    rdy_mode = 0;
    repeat (10) @(negedge clk);
    rdy_mode = 1;
    push(3 * W, W, 0);
    wait_out(2 * W, 2);
    do_reset();
    rdy_mode = 0;
    fill_img(5, 2);
    build_exp(0, 3);
    push(0, 4 * W, 0);
    #2;
    chk("full_ready", s_axis_ready, 0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      i_datavalid = 1;
      idata = 8'(img[4][0]);
      #2;
      if (s_axis_ready) n++;
    end
    chk("full_block", n, 0);
    rdy_mode = 2;
    push(4 * W, W, 20);
    wait_out(3 * W, 3);
    do_reset();
    fill_img(W + 2, 3);
    build_exp(0, W);
    push(0, (W + 2) * W, 25);
    wait_out(W * W, W);
    do_reset();
    rdy_mode = 1;
    fill_img(4, 2);
    build_exp(0, 2);
    push(0, 3 * W + 3, 0);
    wait_got(4);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #2;
    chk("mid_rst_valid", o_datavalid, 0);
    chk("mid_rst_intr", intr, 0);
    chk("mid_rst_ready", s_axis_ready, 1);
    chk("mid_rst_data", odata, 0);
    do_reset();
    rdy_mode = 2;
    fill_img(4, 2);
    build_exp(0, 2);
    push(0, 4 * W, 10);
    wait_out(2 * W, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
